bp_cce_branch_bht: RTL and testbench
====================================

Name: bp_cce_branch_bht

Overview:
- CCE branch unit with a branch history table (BHT) for prediction.
- Resolves branches in execute using unsigned and signed compares, reports mispredicts and produces the next PC.
- Trains a table of per-PC 2-bit saturating counters and supplies taken/not-taken predictions to fetch.
- Keeps saturating branch and mispredict event counters for performance debug.

Parameters:
- width_p, 64: compare operand width.
- cce_pc_width_p, 8: microcode PC width.
- bht_entries_p, 16: BHT entries. Power of two, 2 to 2^cce_pc_width_p.
- stat_width_p, 16: width of each event counter.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- fetch_pc_i  in  cce_pc_width_p  PC being fetched.
- predict_taken_o  out  1  prediction for fetch_pc_i.
- execute_v_i  in  1  execute stage holds a valid, non-stalled instruction.
- branch_i  in  1  execute instruction is a branch.
- predicted_taken_i  in  1  prediction carried down the pipe with the instruction.
- branch_op_i  in  3  0 eq, 1 neq, 2 ltu, 3 leu, 4 lts, 5 les, 6-7 never taken.
- opd_a_i, opd_b_i  in  width_p  compare operands.
- execute_pc_i  in  cce_pc_width_p  PC of the execute instruction.
- branch_target_i  in  cce_pc_width_p  branch target.
- mispredict_o  out  1  resolved direction differs from the prediction.
- pc_o  out  cce_pc_width_p  correct next PC.
- stat_clear_i  in  1  synchronous clear of the event counters.
- branch_count_o  out  stat_width_p  resolved branches.
- mispredict_count_o  out  stat_width_p  mispredicts.

Behaviour:
- Reset (asynchronous, reset_n_i low):
  - All BHT counters go to 2'b01 (weakly not taken).
  - Both event counters go to 0.
  - Combinational outputs simply follow their inputs; predict_taken_o therefore reads 0 while reset is asserted.
  - Deassertion takes effect at the next clk_i edge.
- Index: idx(pc) = pc[log2(bht_entries_p)-1:0].
- Predict (combinational, zero latency):
  - predict_taken_o = BHT[idx(fetch_pc_i)][1].
- Resolve (combinational):
  - ltu/leu compare unsigned; lts/les compare two's-complement signed at width_p.
  - res = compare result per op; ops 6-7 give res = 0.
  - take = execute_v_i & branch_i & res.
  - mispredict_o = execute_v_i & branch_i & (predicted_taken_i ^ res).
  - pc_o = take ? branch_target_i : execute_pc_i + 1, truncated to cce_pc_width_p. 2^cce_pc_width_p - 1 wraps to 0.
  - When execute_v_i = 0: mispredict_o = 0 and pc_o = execute_pc_i + 1.
- Train (posedge clk_i, when execute_v_i & branch_i):
  - Counter at idx(execute_pc_i) increments if res, else decrements.
  - Saturates at 2'b11 and 2'b00.
  - No other entry changes.
  - Non-branch and invalid cycles leave the table unchanged.
- Read/write collision: when fetch_pc_i and execute_pc_i map to the same index in the same cycle, predict_taken_o reflects the pre-update value. No bypass.
- Event counters (posedge clk_i):
  - branch_count_o increments on each execute_v_i & branch_i.
  - mispredict_count_o increments when mispredict_o = 1.
  - Both saturate at all-ones; no wrap.
  - stat_clear_i has priority: both counters go to 0 that cycle, and the event in that same cycle is not counted.
- State: per-entry 2-bit counters (00 SNT, 01 WNT, 10 WT, 11 ST) plus the two event counters.
- Table implementation: flops, not SRAM, so reset initialisation is complete.

Test Plan:
1. Reset, then fetch_pc_i = 0x05 -> predict_taken_o = 0. All counters read 0.
2. Four taken beq at execute_pc_i = 0x05, opd_a = opd_b = 7, predicted_taken_i = 0 ->
   - cycle 1: mispredict_o = 1, pc_o = branch_target_i.
   - predict_taken_o for 0x05 reads 1 after the 1st update.
   - counter saturates at 11.
   - branch_count_o = 4, mispredict_count_o = 4.
   - two not-taken updates then return the prediction to 0.
3. blts vs bltu with opd_a = 0xFFFF_FFFF_FFFF_FFFF, opd_b = 1 (width_p = 64) ->
   - lts: res = 1.
   - ltu: res = 0, with pc_o = execute_pc_i + 1.
   - op 7 is never taken.
4. execute_pc_i = 0xFF, not-taken branch -> pc_o = 0x00. Aliasing check: PCs 0x03 and 0x13 (16 entries) train the same counter.
5. Same-cycle collision at index 2, counter starting at 01, taken update -> predict_taken_o = 0 that cycle and 1 the next cycle.
6. Event counters:
   - preload branch_count_o to 0xFFFF with stat_width_p = 16, then one more branch -> count stays 0xFFFF.
   - stat_clear_i together with a branch -> count = 0.
   - reset_n_i pulsed low mid-sequence -> all BHT entries return to 01 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_cce_branch_bht.sv
// ---------------------------------------------------------------------------
// bp_cce_branch_bht
//
// Branch unit for the CCE microcode engine. It resolves conditional branches
// in the execute stage, flags mispredicts, produces the correct next PC, and
// keeps a branch history table of 2-bit saturating counters that supplies
// taken/not-taken predictions to fetch. Two saturating event counters record
// resolved branches and mispredicts for performance debug.
//
// Ports:
//   clk_i               clock
//   reset_n_i           asynchronous active-low reset
//   fetch_pc_i          PC being fetched (prediction lookup)
//   predict_taken_o     prediction for fetch_pc_i
//   execute_v_i         execute stage holds a valid, non-stalled instruction
//   branch_i            execute instruction is a branch
//   predicted_taken_i   prediction carried down the pipe with the instruction
//   branch_op_i         0 eq, 1 neq, 2 ltu, 3 leu, 4 lts, 5 les, 6-7 never
//   opd_a_i, opd_b_i    compare operands
//   execute_pc_i        PC of the execute instruction
//   branch_target_i     branch target PC
//   mispredict_o        resolved direction differs from the prediction
//   pc_o                correct next PC
//   stat_clear_i        synchronous clear of the event counters
//   branch_count_o      number of resolved branches (saturating)
//   mispredict_count_o  number of mispredicts (saturating)
// ---------------------------------------------------------------------------
module bp_cce_branch_bht #(
   parameter int width_p        = 64,
   parameter int cce_pc_width_p = 8,
   parameter int bht_entries_p  = 16,
   parameter int stat_width_p   = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,

   input  logic [cce_pc_width_p-1:0] fetch_pc_i,
   output logic                      predict_taken_o,

   input  logic                      execute_v_i,
   input  logic                      branch_i,
   input  logic                      predicted_taken_i,
   input  logic [2:0]                branch_op_i,
   input  logic [width_p-1:0]        opd_a_i,
   input  logic [width_p-1:0]        opd_b_i,
   input  logic [cce_pc_width_p-1:0] execute_pc_i,
   input  logic [cce_pc_width_p-1:0] branch_target_i,
   output logic                      mispredict_o,
   output logic [cce_pc_width_p-1:0] pc_o,

   input  logic                      stat_clear_i,
   output logic [stat_width_p-1:0]   branch_count_o,
   output logic [stat_width_p-1:0]   mispredict_count_o
);

   localparam int idx_width_lp = (bht_entries_p > 1) ? $clog2(bht_entries_p) : 1;

   // Branch op encodings
   localparam logic [2:0] op_eq_lp  = 3'd0;
   localparam logic [2:0] op_neq_lp = 3'd1;
   localparam logic [2:0] op_ltu_lp = 3'd2;
   localparam logic [2:0] op_leu_lp = 3'd3;
   localparam logic [2:0] op_lts_lp = 3'd4;
   localparam logic [2:0] op_les_lp = 3'd5;

   logic [1:0]                bht_r [bht_entries_p];
   logic [idx_width_lp-1:0]   fetch_idx;
   logic [idx_width_lp-1:0]   exec_idx;

   logic                      opd_eq;
   logic                      opd_ltu;
   logic                      opd_lts;
   logic                      res;
   logic                      train_v;
   logic                      take;
   logic [cce_pc_width_p-1:0] pc_plus_one;

   logic [stat_width_p-1:0]   branch_count_r;
   logic [stat_width_p-1:0]   mispredict_count_r;

   // The table is indexed by the low PC bits only, so PCs that differ only
   // in their upper bits alias onto the same counter.
   assign fetch_idx = fetch_pc_i[idx_width_lp-1:0];
   assign exec_idx  = execute_pc_i[idx_width_lp-1:0];

   // Upper PC bits play no part in indexing; fold them into a sink so the
   // intent of leaving them unused is explicit.
   generate
      if (idx_width_lp < cce_pc_width_p) begin : g_pc_upper
         logic unused_pc_upper;
         assign unused_pc_upper = ^{fetch_pc_i[cce_pc_width_p-1:idx_width_lp],
                                    execute_pc_i[cce_pc_width_p-1:idx_width_lp]};
      end
   endgenerate

   // Prediction is a plain read of the counter's upper bit. It is deliberately
   // not bypassed from a same-cycle training write, so a collision between
   // fetch and execute on one index returns the pre-update direction.
   assign predict_taken_o = bht_r[fetch_idx][1];

   // Operand compares shared by all branch ops. Signed ops reinterpret the
   // operands as two's complement at the full operand width.
   assign opd_eq  = (opd_a_i == opd_b_i);
   assign opd_ltu = (opd_a_i < opd_b_i);
   assign opd_lts = ($signed(opd_a_i) < $signed(opd_b_i));

   // Select the resolved direction for the current op. Ops 6 and 7 are
   // defined as never taken, which the default covers.
   always_comb begin
      res = 1'b0;
      case (branch_op_i)
         op_eq_lp:  res = opd_eq;
         op_neq_lp: res = ~opd_eq;
         op_ltu_lp: res = opd_ltu;
         op_leu_lp: res = opd_ltu | opd_eq;
         op_lts_lp: res = opd_lts;
         op_les_lp: res = opd_lts | opd_eq;
         default:   res = 1'b0;
      endcase
   end

   // A branch only counts, trains or redirects when execute holds a valid
   // branch. The fall-through PC wraps naturally at the PC width.
   assign train_v      = execute_v_i & branch_i;
   assign take         = train_v & res;
   assign mispredict_o = train_v & (predicted_taken_i ^ res);
   assign pc_plus_one  = execute_pc_i + cce_pc_width_p'(1);
   assign pc_o         = take ? branch_target_i : pc_plus_one;

   // History table update. Every entry resets to weakly-not-taken; on a
   // resolved branch only the entry at the execute PC moves one step toward
   // the resolved direction, holding at the strong ends.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < bht_entries_p; i++) begin
            bht_r[i] <= 2'b01;
         end
      end else if (train_v) begin
         if (res) begin
            if (bht_r[exec_idx] != 2'b11) begin
               bht_r[exec_idx] <= bht_r[exec_idx] + 2'd1;
            end
         end else begin
            if (bht_r[exec_idx] != 2'b00) begin
               bht_r[exec_idx] <= bht_r[exec_idx] - 2'd1;
            end
         end
      end
   end

   // Event counters. A clear wins over any event in the same cycle, and the
   // counters stick at all-ones rather than wrapping so long runs stay
   // readable as "at least this many".
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         branch_count_r     <= '0;
         mispredict_count_r <= '0;
      end else if (stat_clear_i) begin
         branch_count_r     <= '0;
         mispredict_count_r <= '0;
      end else begin
         if (train_v && !(&branch_count_r)) begin
            branch_count_r <= branch_count_r + stat_width_p'(1);
         end
         if (mispredict_o && !(&mispredict_count_r)) begin
            mispredict_count_r <= mispredict_count_r + stat_width_p'(1);
         end
      end
   end

   assign branch_count_o     = branch_count_r;
   assign mispredict_count_o = mispredict_count_r;

endmodule

// File: tb/tb_bp_cce_branch_bht.sv
// ---------------------------------------------------------------------------
// tb_bp_cce_branch_bht
//
// Directed testbench for bp_cce_branch_bht with the default configuration
// (64-bit operands, 8-bit PCs, 16 BHT entries, 16-bit event counters).
// Expected values are hand-computed constants for each vector.
// ---------------------------------------------------------------------------
module tb_bp_cce_branch_bht;

   logic        clk_i;
   logic        reset_n_i;
   logic [7:0]  fetch_pc_i;
   logic        predict_taken_o;
   logic        execute_v_i;
   logic        branch_i;
   logic        predicted_taken_i;
   logic [2:0]  branch_op_i;
   logic [63:0] opd_a_i;
   logic [63:0] opd_b_i;
   logic [7:0]  execute_pc_i;
   logic [7:0]  branch_target_i;
   logic        mispredict_o;
   logic [7:0]  pc_o;
   logic        stat_clear_i;
   logic [15:0] branch_count_o;
   logic [15:0] mispredict_count_o;

   int checkCount;
   int errorCount;

   localparam logic [63:0] allOnes = 64'hFFFF_FFFF_FFFF_FFFF;

   bp_cce_branch_bht #(
      .width_p        (64),
      .cce_pc_width_p (8),
      .bht_entries_p  (16),
      .stat_width_p   (16)
   ) dut (
      .clk_i              (clk_i),
      .reset_n_i          (reset_n_i),
      .fetch_pc_i         (fetch_pc_i),
      .predict_taken_o    (predict_taken_o),
      .execute_v_i        (execute_v_i),
      .branch_i           (branch_i),
      .predicted_taken_i  (predicted_taken_i),
      .branch_op_i        (branch_op_i),
      .opd_a_i            (opd_a_i),
      .opd_b_i            (opd_b_i),
      .execute_pc_i       (execute_pc_i),
      .branch_target_i    (branch_target_i),
      .mispredict_o       (mispredict_o),
      .pc_o               (pc_o),
      .stat_clear_i       (stat_clear_i),
      .branch_count_o     (branch_count_o),
      .mispredict_count_o (mispredict_count_o)
   );

   // Free-running clock, posedge at 5, 15, 25, ...
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Compare one observed value against its expected value and log misses.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one full input vector and let the combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic br, input logic pred,
                                input logic clr, input logic [2:0] op,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [7:0] epc, input logic [7:0] tgt,
                                input logic [7:0] fpc);
      execute_v_i       = v;
      branch_i          = br;
      predicted_taken_i = pred;
      stat_clear_i      = clr;
      branch_op_i       = op;
      opd_a_i           = a;
      opd_b_i           = b;
      execute_pc_i      = epc;
      branch_target_i   = tgt;
      fetch_pc_i        = fpc;
      #1;
   endtask

   // Advance past one rising edge and sample 1 ns after it.
   task automatic clockCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idleCycle(input logic [7:0] fpc);
      applyStimulus(0, 0, 0, 0, 3'd0, 64'd0, 64'd0, 8'h00, 8'h00, fpc);
      clockCycle();
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      $display("[TB] starting bp_cce_branch_bht directed test");

      // Reset state: prediction and counters read zero while reset is held.
      reset_n_i = 1'b0;
      applyStimulus(0, 0, 0, 0, 3'd0, 64'd0, 64'd0, 8'h00, 8'h00, 8'h05);
      checkOutput("rst_predict", predict_taken_o, 0);
      checkOutput("rst_branch_cnt", branch_count_o, 0);
      checkOutput("rst_mispred_cnt", mispredict_count_o, 0);
      checkOutput("rst_idle_pc", pc_o, 8'h01);
      clockCycle();
      clockCycle();
      reset_n_i = 1'b1;
      idleCycle(8'h05);
      checkOutput("post_rst_predict", predict_taken_o, 0);

      // Four taken beq at 0x05 predicted not-taken: 01 -> 10 -> 11 -> 11 -> 11.
      applyStimulus(1, 1, 0, 0, 3'd0, 64'd7, 64'd7, 8'h05, 8'h40, 8'h05);
      checkOutput("beq_mispredict", mispredict_o, 1);
      checkOutput("beq_pc", pc_o, 8'h40);
      checkOutput("beq_pre_predict", predict_taken_o, 0);
      for (int i = 1; i <= 4; i++) begin
         clockCycle();
         checkOutput($sformatf("beq_predict_%0d", i), predict_taken_o, 1);
      end
      checkOutput("beq_branch_cnt", branch_count_o, 4);
      checkOutput("beq_mispred_cnt", mispredict_count_o, 4);

      // Two not-taken (neq with equal operands) updates: 11 -> 10 -> 01.
      applyStimulus(1, 1, 1, 0, 3'd1, 64'd7, 64'd7, 8'h05, 8'h40, 8'h05);
      checkOutput("bne_mispredict", mispredict_o, 1);
      checkOutput("bne_pc", pc_o, 8'h06);
      clockCycle();
      checkOutput("bne_predict_1", predict_taken_o, 1);
      clockCycle();
      checkOutput("bne_predict_2", predict_taken_o, 0);
      checkOutput("bne_branch_cnt", branch_count_o, 6);
      checkOutput("bne_mispred_cnt", mispredict_count_o, 6);
      idleCycle(8'h05);

      // Signed vs unsigned compares with a = -1 / 0xFF..FF, b = 1.
      applyStimulus(1, 1, 0, 0, 3'd4, allOnes, 64'd1, 8'h20, 8'h33, 8'h00);
      checkOutput("lts_mispredict", mispredict_o, 1);
      checkOutput("lts_pc", pc_o, 8'h33);
      applyStimulus(1, 1, 0, 0, 3'd2, allOnes, 64'd1, 8'h20, 8'h33, 8'h00);
      checkOutput("ltu_mispredict", mispredict_o, 0);
      checkOutput("ltu_pc", pc_o, 8'h21);
      applyStimulus(1, 1, 0, 0, 3'd7, 64'd7, 64'd7, 8'h20, 8'h33, 8'h00);
      checkOutput("op7_mispredict_p0", mispredict_o, 0);
      checkOutput("op7_pc", pc_o, 8'h21);
      applyStimulus(1, 1, 1, 0, 3'd7, 64'd7, 64'd7, 8'h20, 8'h33, 8'h00);
      checkOutput("op7_mispredict_p1", mispredict_o, 1);
      idleCycle(8'h00);

      applyStimulus(1, 1, 1, 0, 3'd3, 64'd7, 64'd7, 8'h20, 8'h33, 8'h00);
      checkOutput("leu_eq_pc", pc_o, 8'h33);
      checkOutput("leu_eq_mispredict", mispredict_o, 0);
      applyStimulus(1, 1, 1, 0, 3'd5, allOnes, 64'd1, 8'h20, 8'h33, 8'h00);
      checkOutput("les_pc", pc_o, 8'h33);
      applyStimulus(1, 1, 0, 0, 3'd5, 64'd1, allOnes, 8'h20, 8'h33, 8'h00);
      checkOutput("les_not_taken_pc", pc_o, 8'h21);
      applyStimulus(0, 1, 1, 0, 3'd0, 64'd7, 64'd7, 8'h20, 8'h33, 8'h00);
      checkOutput("invalid_mispredict", mispredict_o, 0);
      checkOutput("invalid_pc", pc_o, 8'h21);
      idleCycle(8'h00);
      checkOutput("compare_only_branch_cnt", branch_count_o, 6);

      // PC wrap on fall-through from the last PC.
      applyStimulus(1, 1, 0, 0, 3'd1, 64'd3, 64'd3, 8'hFF, 8'h50, 8'h00);
      checkOutput("wrap_pc", pc_o, 8'h00);
      checkOutput("wrap_mispredict", mispredict_o, 0);
      idleCycle(8'h00);

      // Aliasing: 0x03 and 0x13 share index 3.
      applyStimulus(1, 1, 0, 0, 3'd0, 64'd3, 64'd3, 8'h03, 8'h50, 8'h13);
      checkOutput("alias_pre_predict", predict_taken_o, 0);
      clockCycle();
      checkOutput("alias_predict_13", predict_taken_o, 1);
      applyStimulus(1, 1, 0, 0, 3'd1, 64'd3, 64'd3, 8'h13, 8'h50, 8'h03);
      checkOutput("alias_predict_03_pre", predict_taken_o, 1);
      clockCycle();
      checkOutput("alias_predict_03", predict_taken_o, 0);
      idleCycle(8'h00);
      checkOutput("alias_branch_cnt", branch_count_o, 8);
      checkOutput("alias_mispred_cnt", mispredict_count_o, 7);

      // Same-cycle collision at index 2: no bypass of the update.
      applyStimulus(1, 1, 0, 0, 3'd0, 64'd9, 64'd9, 8'h02, 8'h60, 8'h02);
      checkOutput("collide_same_cycle", predict_taken_o, 0);
      clockCycle();
      checkOutput("collide_next_cycle", predict_taken_o, 1);
      idleCycle(8'h02);
      checkOutput("idle_keeps_predict", predict_taken_o, 1);
      checkOutput("collide_branch_cnt", branch_count_o, 9);
      checkOutput("collide_mispred_cnt", mispredict_count_o, 8);

      // Clear with a simultaneous branch: the event is not counted.
      applyStimulus(1, 1, 0, 1, 3'd0, 64'd1, 64'd1, 8'h07, 8'h70, 8'h07);
      clockCycle();
      checkOutput("clear_branch_cnt", branch_count_o, 0);
      checkOutput("clear_mispred_cnt", mispredict_count_o, 0);

      // Saturation: 65535 mispredicted branches reach all-ones, one more holds.
      applyStimulus(1, 1, 0, 0, 3'd0, 64'd1, 64'd1, 8'h07, 8'h70, 8'h07);
      repeat (65535) clockCycle();
      checkOutput("sat_branch_cnt", branch_count_o, 16'hFFFF);
      checkOutput("sat_mispred_cnt", mispredict_count_o, 16'hFFFF);
      clockCycle();
      checkOutput("sat_hold_branch_cnt", branch_count_o, 16'hFFFF);
      checkOutput("sat_hold_mispred_cnt", mispredict_count_o, 16'hFFFF);
      applyStimulus(1, 1, 0, 1, 3'd0, 64'd1, 64'd1, 8'h07, 8'h70, 8'h07);
      clockCycle();
      checkOutput("sat_clear_branch_cnt", branch_count_o, 0);
      checkOutput("sat_clear_mispred_cnt", mispredict_count_o, 0);
      idleCycle(8'h07);
      checkOutput("pre_pulse_predict", predict_taken_o, 1);

      // Asynchronous reset pulse between edges clears the table immediately.
      #1;
      reset_n_i = 1'b0;
      #1;
      checkOutput("pulse_predict_07", predict_taken_o, 0);
      checkOutput("pulse_predict_02", dut.bht_r[2], 2'b01);
      for (int i = 0; i < 16; i++) begin
         fetch_pc_i = 8'(i);
         #1;
         checkOutput($sformatf("pulse_predict_idx%0d", i), predict_taken_o, 0);
      end
      clockCycle();
      reset_n_i = 1'b1;

      // One taken update after reset must flip index 7 to taken (01 -> 10).
      applyStimulus(1, 1, 0, 0, 3'd0, 64'd1, 64'd1, 8'h07, 8'h70, 8'h07);
      checkOutput("post_pulse_pre_predict", predict_taken_o, 0);
      clockCycle();
      checkOutput("post_pulse_predict", predict_taken_o, 1);
      checkOutput("post_pulse_branch_cnt", branch_count_o, 1);
      idleCycle(8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
